// File: rtl/cfg_space_arbiter_if.sv
// Bundle of the two requester ports and the configuration-space port that
// cfg_space_arbiter serves.
//   slave  : arbiter view (takes requests and c_data_out, drives everything else)
//   master : environment view (requesters plus the config-space responder)
interface cfg_space_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  // requester 0: sideband register-access handler
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req0_rvalid;
  logic [DATA_W-1:0] req0_rdata;
  // requester 1: lane-adapter training FSM
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              req1_rvalid;
  logic [DATA_W-1:0] req1_rdata;
  // shared configuration-space port
  logic              c_read;
  logic              c_write;
  logic [ADDR_W-1:0] c_address;
  logic [DATA_W-1:0] c_data_in;
  logic [DATA_W-1:0] c_data_out;
  logic              busy;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  c_data_out,
    output req0_ready, req0_rvalid, req0_rdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output c_read, c_write, c_address, c_data_in, busy
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output c_data_out,
    input  req0_ready, req0_rvalid, req0_rdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  c_read, c_write, c_address, c_data_in, busy
  );
endinterface

// File: rtl/cfg_space_arbiter.sv
// Round-robin arbiter sharing one configuration-space port between two
// requesters. One transaction at a time; reads return after a fixed RD_LAT
// and are routed back to the requester that issued them.
// Ports:
//   sb_clk : clock, all logic on rising edge
//   rst    : synchronous active-high reset
//   bus    : cfg_space_arbiter_if.slave (requester handshakes + config port)
module cfg_space_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                  sb_clk,
  input  logic                  rst,
  cfg_space_arbiter_if.slave    bus
);

  if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
    $error("cfg_space_arbiter: RD_LAT must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_RD, RETURN} state_e;

  state_e                       state_q, state_d;
  logic                         rr_q, rr_d;
  logic                         win_q, win_d;
  logic [3:0]                   cnt_q, cnt_d;
  logic                         rd_q, rd_d;
  logic                         wr_q, wr_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [DATA_W-1:0]            din_q, din_d;
  logic [1:0]                   ready_q, ready_d;
  logic [1:0]                   rvalid_q, rvalid_d;
  logic [1:0][DATA_W-1:0]       rdata_q, rdata_d;
  logic                         busy_q, busy_d;

  // A requester whose ready pulse is showing this cycle is still presenting
  // the request just accepted (it only moves on after seeing ready), so it
  // is masked to avoid issuing the same transaction twice.
  logic [1:0]        vld;
  logic              gnt;
  logic              gnt_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  assign vld       = {bus.req1_valid, bus.req0_valid} & ~ready_q;
  assign gnt       = (&vld) ? rr_q : vld[1];
  assign gnt_wr    = gnt ? bus.req1_write : bus.req0_write;
  assign gnt_addr  = gnt ? bus.req1_addr  : bus.req0_addr;
  assign gnt_wdata = gnt ? bus.req1_wdata : bus.req0_wdata;

  always_ff @(posedge sb_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      win_q    <= 1'b0;
      cnt_q    <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      ready_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      win_q    <= win_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    cnt_d    = cnt_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    ready_d  = '0;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    busy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|vld) begin
          ready_d[gnt] = 1'b1;
          win_d        = gnt;
          rr_d         = ~gnt;
          addr_d       = gnt_addr;
          busy_d       = 1'b1;
          if (gnt_wr) begin
            // writes complete on the strobe; stay in IDLE
            wr_d  = 1'b1;
            din_d = gnt_wdata;
          end else begin
            rd_d    = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        busy_d = 1'b1;
        if (cnt_q == 4'd0) state_d = RETURN;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RETURN: begin
        // c_data_out is valid exactly RD_LAT cycles after the strobe: now
        rvalid_d[win_q] = 1'b1;
        rdata_d[win_q]  = bus.c_data_out;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req0_ready  = ready_q[0];
  assign bus.req1_ready  = ready_q[1];
  assign bus.req0_rvalid = rvalid_q[0];
  assign bus.req1_rvalid = rvalid_q[1];
  assign bus.req0_rdata  = rdata_q[0];
  assign bus.req1_rdata  = rdata_q[1];
  assign bus.c_read      = rd_q;
  assign bus.c_write     = wr_q;
  assign bus.c_address   = addr_q;
  assign bus.c_data_in   = din_q;
  assign bus.busy        = busy_q;

endmodule
